// File: rtl/psram_pkg.sv
// psram_pkg: shared definitions for the PSRAM arbiter slice.
//   - command codes presented to the PSRAM controller (read_write)
//   - arbiter FSM state encoding
//   - requester port identifiers
//   - default PSRAM address / data widths
//   - rw_legal(): true only for the WRITE and READ command codes
package psram_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 23;
  localparam int unsigned DEFAULT_DATA_W = 16;

  // Controller command codes; 00 doubles as "no command" and 11 is never legal.
  localparam logic [1:0] RW_NOP     = 2'b00;
  localparam logic [1:0] RW_WRITE   = 2'b01;
  localparam logic [1:0] RW_READ    = 2'b10;
  localparam logic [1:0] RW_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_END = 2'b10,
    ST_RELEASE  = 2'b11
  } state_e;

  typedef enum logic {
    PORT_ACQ = 1'b0,
    PORT_RD  = 1'b1
  } port_e;

  function automatic logic rw_legal(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: bundles both requester ports and the PSRAM controller
// command/completion signals of the arbiter.
//   Requester side (per port acq = acquisition writer, rd = UART readout):
//     req_*, rw_*, addr_*, wdata_*  request level, command code, address, data
//     gnt_*, done_*                 grant and completion pulses
//     rdata                         read data, valid with done_rd
//   Controller side:
//     quad_start, read_write, address, data_in   command to the controller
//     endcommand, data_out                       completion and read data
//   Status:
//     timeout_err                   sticky abort flag
// Modports: slave = arbiter view, master = requester/controller view.
interface psram_arbiter_if #(
  parameter int unsigned ADDR_W = psram_pkg::DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = psram_pkg::DEFAULT_DATA_W
);

  logic              req_acq;
  logic [1:0]        rw_acq;
  logic [ADDR_W-1:0] addr_acq;
  logic [DATA_W-1:0] wdata_acq;
  logic              gnt_acq;
  logic              done_acq;

  logic              req_rd;
  logic [1:0]        rw_rd;
  logic [ADDR_W-1:0] addr_rd;
  logic [DATA_W-1:0] wdata_rd;
  logic              gnt_rd;
  logic              done_rd;

  logic [DATA_W-1:0] rdata;

  logic              quad_start;
  logic [1:0]        read_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              endcommand;
  logic [DATA_W-1:0] data_out;

  logic              timeout_err;

  modport slave (
    input  req_acq, rw_acq, addr_acq, wdata_acq,
    input  req_rd, rw_rd, addr_rd, wdata_rd,
    input  endcommand, data_out,
    output gnt_acq, done_acq, gnt_rd, done_rd, rdata,
    output quad_start, read_write, address, data_in,
    output timeout_err
  );

  modport master (
    output req_acq, rw_acq, addr_acq, wdata_acq,
    output req_rd, rw_rd, addr_rd, wdata_rd,
    output endcommand, data_out,
    input  gnt_acq, done_acq, gnt_rd, done_rd, rdata,
    input  quad_start, read_write, address, data_in,
    input  timeout_err
  );

endinterface

// File: rtl/psram_timeout_counter.sv
// psram_timeout_counter: loadable down-counter guarding the WAIT_END state.
//   clk, rst   clock and asynchronous active-high reset (clears the count)
//   load       reloads the count so that expiry falls on the TIMEOUT-th
//              enabled cycle
//   en         counts down one step per cycle, saturating at zero
//   expired_c  combinational: enabled and count at zero
module psram_timeout_counter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // Loaded with TIMEOUT-1 so the first enabled cycle is cycle 1 of TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT - 1);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired_c = en && (count == '0);

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port arbiter in front of a quad-SPI PSRAM controller.
//   clk_PSRAM  84 MHz single clock domain
//   reset      asynchronous active-high reset
//   bus        psram_arbiter_if.slave: requester ports (acq = port 0,
//              rd = port 1), controller command/completion, timeout_err
// FSM: IDLE -> ISSUE -> WAIT_END -> RELEASE -> IDLE. An illegal command
// code goes ISSUE -> RELEASE with a done pulse and no quad_start.
// Optional feature: define ARB_ROUND_ROBIN_EN to let the port not served
// last win simultaneous requests; otherwise acquisition always wins.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk_PSRAM,
  input  logic             reset,
  psram_arbiter_if.slave   bus
);

  state_e state, state_nxt;

  // Registered outputs and their next values
  logic              gnt_acq, gnt_acq_nxt;
  logic              gnt_rd, gnt_rd_nxt;
  logic              done_acq, done_acq_nxt;
  logic              done_rd, done_rd_nxt;
  logic [DATA_W-1:0] rdata, rdata_nxt;
  logic              quad_start, quad_start_nxt;
  logic [1:0]        cmd_rw, cmd_rw_nxt;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;
  logic              timeout_err, timeout_err_nxt;
  port_e             owner, owner_nxt;

  logic  any_req_c;
  port_e winner_c;
  logic  grant_c;
  logic  tmo_load_c;
  logic  tmo_en_c;
  logic  expired_c;

  assign any_req_c = bus.req_acq || bus.req_rd;
  assign grant_c   = (state == ST_IDLE) && any_req_c;

`ifdef ARB_ROUND_ROBIN_EN
  port_e last_port;

  // Remembers the port granted most recently; reset favours readout next.
  always_ff @(posedge clk_PSRAM or posedge reset) begin
    if (reset) begin
      last_port <= PORT_ACQ;
    end else if (grant_c) begin
      last_port <= winner_c;
    end
  end
`endif

  // Winner selection among pending requests
  always_comb begin
    winner_c = PORT_ACQ;
    if (bus.req_acq && bus.req_rd) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner_c = (last_port == PORT_ACQ) ? PORT_RD : PORT_ACQ;
`else
      winner_c = PORT_ACQ;
`endif
    end else if (bus.req_rd) begin
      winner_c = PORT_RD;
    end
  end

  // WAIT_END watchdog: armed while issuing, counts while waiting
  assign tmo_load_c = (state == ST_ISSUE);
  assign tmo_en_c   = (state == ST_WAIT_END);

  psram_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk_PSRAM),
    .rst       (reset),
    .load      (tmo_load_c),
    .en        (tmo_en_c),
    .expired_c (expired_c)
  );

  // State register
  always_ff @(posedge clk_PSRAM or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (any_req_c) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = rw_legal(cmd_rw) ? ST_WAIT_END : ST_RELEASE;
      end
      ST_WAIT_END: begin
        if (bus.endcommand || expired_c) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    gnt_acq_nxt     = 1'b0;
    gnt_rd_nxt      = 1'b0;
    done_acq_nxt    = 1'b0;
    done_rd_nxt     = 1'b0;
    quad_start_nxt  = 1'b0;
    rdata_nxt       = rdata;
    cmd_rw_nxt      = cmd_rw;
    cmd_addr_nxt    = cmd_addr;
    cmd_wdata_nxt   = cmd_wdata;
    timeout_err_nxt = timeout_err;
    owner_nxt       = owner;

    unique case (state)
      ST_IDLE: begin
        if (any_req_c) begin
          owner_nxt = winner_c;
          if (winner_c == PORT_ACQ) begin
            gnt_acq_nxt   = 1'b1;
            cmd_rw_nxt    = bus.rw_acq;
            cmd_addr_nxt  = bus.addr_acq;
            cmd_wdata_nxt = bus.wdata_acq;
          end else begin
            gnt_rd_nxt    = 1'b1;
            cmd_rw_nxt    = bus.rw_rd;
            cmd_addr_nxt  = bus.addr_rd;
            cmd_wdata_nxt = bus.wdata_rd;
          end
        end
      end

      ST_ISSUE: begin
        if (rw_legal(cmd_rw)) begin
          quad_start_nxt = 1'b1;
        end else begin
          // Illegal code: complete straight away without touching the PSRAM
          done_acq_nxt = (owner == PORT_ACQ);
          done_rd_nxt  = (owner == PORT_RD);
          cmd_rw_nxt   = RW_NOP;
        end
      end

      ST_WAIT_END: begin
        // A completion arriving on the expiry cycle still counts as success
        if (bus.endcommand) begin
          done_acq_nxt = (owner == PORT_ACQ);
          done_rd_nxt  = (owner == PORT_RD);
          if (cmd_rw == RW_READ) rdata_nxt = bus.data_out;
          cmd_rw_nxt   = RW_NOP;
        end else if (expired_c) begin
          done_acq_nxt    = (owner == PORT_ACQ);
          done_rd_nxt     = (owner == PORT_RD);
          timeout_err_nxt = 1'b1;
          cmd_rw_nxt      = RW_NOP;
        end
      end

      ST_RELEASE: begin
      end

      default: begin
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk_PSRAM or posedge reset) begin
    if (reset) begin
      gnt_acq     <= 1'b0;
      gnt_rd      <= 1'b0;
      done_acq    <= 1'b0;
      done_rd     <= 1'b0;
      quad_start  <= 1'b0;
      rdata       <= '0;
      cmd_rw      <= RW_NOP;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      timeout_err <= 1'b0;
      owner       <= PORT_ACQ;
    end else begin
      gnt_acq     <= gnt_acq_nxt;
      gnt_rd      <= gnt_rd_nxt;
      done_acq    <= done_acq_nxt;
      done_rd     <= done_rd_nxt;
      quad_start  <= quad_start_nxt;
      rdata       <= rdata_nxt;
      cmd_rw      <= cmd_rw_nxt;
      cmd_addr    <= cmd_addr_nxt;
      cmd_wdata   <= cmd_wdata_nxt;
      timeout_err <= timeout_err_nxt;
      owner       <= owner_nxt;
    end
  end

  assign bus.gnt_acq     = gnt_acq;
  assign bus.gnt_rd      = gnt_rd;
  assign bus.done_acq    = done_acq;
  assign bus.done_rd     = done_rd;
  assign bus.rdata       = rdata;
  assign bus.quad_start  = quad_start;
  assign bus.read_write  = cmd_rw;
  assign bus.address     = cmd_addr;
  assign bus.data_in     = cmd_wdata;
  assign bus.timeout_err = timeout_err;

endmodule
